// File: rtl/nco_bank_sync.sv
// Bank of code/carrier NCO pairs with shadowed tuning registers.
// A global commit applies every channel's shadows on the same edge.
module nco_bank_sync #(
    parameter int NCH      = 8,
    parameter int ACC_W    = 28,
    parameter int CODE_LEN = 1023,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [3:0]           wr_ch,
    input  logic [1:0]           wr_reg,
    input  logic [ACC_W-1:0]     wr_data,
    input  logic                 commit,
    output logic [NCH-1:0]       clk_code,
    output logic [NCH-1:0]       clk_carr,
    output logic [NCH-1:0]       chip_tick,
    output logic [NCH-1:0]       epoch,
    output logic [NCH*CNT_W-1:0] chip_cnt
);

    localparam logic [1:0] REG_FRE_CODE = 2'd0;
    localparam logic [1:0] REG_PHA_CODE = 2'd1;
    localparam logic [1:0] REG_FRE_CARR = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(CODE_LEN - 1);

    logic [ACC_W-1:0] sh_fre_code [NCH];
    logic [ACC_W-1:0] sh_pha_code [NCH];
    logic [ACC_W-1:0] sh_fre_carr [NCH];
    logic [NCH-1:0]   sh_en;
    logic [NCH-1:0]   pha_pend;

    logic [ACC_W-1:0] fre_code [NCH];
    logic [ACC_W-1:0] fre_carr [NCH];
    logic [NCH-1:0]   en;

    logic [ACC_W-1:0] code_acc [NCH];
    logic [ACC_W-1:0] carr_acc [NCH];
    logic [CNT_W-1:0] cnt      [NCH];

    logic [ACC_W-1:0] code_sum [NCH];
    logic [ACC_W-1:0] carr_sum [NCH];
    logic [NCH-1:0]   code_cy;
    logic [NCH-1:0]   wr_hit;
    logic [NCH-1:0]   load;

    always_comb begin
        code_cy = '0;
        wr_hit  = '0;
        load    = '0;
        for (int k = 0; k < NCH; k++) begin
            {code_cy[k], code_sum[k]} = {1'b0, code_acc[k]} + {1'b0, fre_code[k]};
            carr_sum[k] = carr_acc[k] + fre_carr[k];
            wr_hit[k]   = wr_en && (wr_ch == 4'(k));
            load[k]     = commit && pha_pend[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_en     <= '0;
            pha_pend  <= '0;
            en        <= '0;
            chip_tick <= '0;
            epoch     <= '0;
            for (int k = 0; k < NCH; k++) begin
                sh_fre_code[k] <= '0;
                sh_pha_code[k] <= '0;
                sh_fre_carr[k] <= '0;
                fre_code[k]    <= '0;
                fre_carr[k]    <= '0;
                code_acc[k]    <= '0;
                carr_acc[k]    <= '0;
                cnt[k]         <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (wr_hit[k]) begin
                    unique case (wr_reg)
                        REG_FRE_CODE: sh_fre_code[k] <= wr_data;
                        REG_PHA_CODE: sh_pha_code[k] <= wr_data;
                        REG_FRE_CARR: sh_fre_carr[k] <= wr_data;
                        REG_CTRL:     sh_en[k]       <= wr_data[0];
                    endcase
                end

                // A phase write landing with a commit stays pending for the next one
                if (wr_hit[k] && (wr_reg == REG_PHA_CODE)) begin
                    pha_pend[k] <= 1'b1;
                end else if (commit) begin
                    pha_pend[k] <= 1'b0;
                end

                if (commit) begin
                    fre_code[k] <= sh_fre_code[k];
                    fre_carr[k] <= sh_fre_carr[k];
                    en[k]       <= sh_en[k];
                end

                if (load[k]) begin
                    code_acc[k]  <= sh_pha_code[k];
                    cnt[k]       <= '0;
                    chip_tick[k] <= 1'b0;
                    epoch[k]     <= 1'b0;
                end else if (en[k]) begin
                    code_acc[k]  <= code_sum[k];
                    chip_tick[k] <= code_cy[k];
                    epoch[k]     <= 1'b0;
                    if (code_cy[k]) begin
                        if (cnt[k] == LAST_CHIP) begin
                            cnt[k]   <= '0;
                            epoch[k] <= 1'b1;
                        end else begin
                            cnt[k] <= cnt[k] + CNT_W'(1);
                        end
                    end
                end else begin
                    chip_tick[k] <= 1'b0;
                    epoch[k]     <= 1'b0;
                end

                // Carrier keeps running through a code phase load
                if (en[k]) begin
                    carr_acc[k] <= carr_sum[k];
                end
            end
        end
    end

    always_comb begin
        clk_code = '0;
        clk_carr = '0;
        chip_cnt = '0;
        for (int k = 0; k < NCH; k++) begin
            clk_code[k] = code_acc[k][ACC_W-1];
            clk_carr[k] = carr_acc[k][ACC_W-1];
            chip_cnt[k*CNT_W +: CNT_W] = cnt[k];
        end
    end

endmodule
